// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier arbiter: defaults and FSM state encoding.
package booth_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/booth_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] owner
);

  int idx;

  // Scan from farthest to nearest so the nearest set bit after ptr is written last.
  always_comb begin
    valid = 1'b0;
    owner = '0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        valid = 1'b1;
        owner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin scheduler sharing one Booth multiplier among N requesters, with a watchdog abort.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int N       = 4,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_m,
  input  logic [N*WIDTH-1:0]   req_q,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_m,
  output logic [WIDTH-1:0]     mul_q,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic [N-1:0]         rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]   rsp_product_q, rsp_product_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_m_q, mul_m_d;
  logic [WIDTH-1:0]     mul_q_q, mul_q_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_owner;
  logic [WIDTH-1:0]     sel_m, sel_q;

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh = '0;
    for (int i = 0; i < N; i++) oh[i] = (IDX_W'(i) == idx);
    return oh;
  endfunction

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .owner (pick_owner)
  );

  always_comb begin
    sel_m = '0;
    sel_q = '0;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) == pick_owner) begin
        sel_m = req_m[i*WIDTH +: WIDTH];
        sel_q = req_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    timer_d       = timer_q;
    gnt_d         = '0;
    rsp_valid_d   = '0;
    mul_start_d   = 1'b0;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    mul_m_d       = mul_m_q;
    mul_q_d       = mul_q_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d     = pick_owner;
          mul_m_d     = sel_m;
          mul_q_d     = sel_q;
          gnt_d       = to_onehot(pick_owner);
          mul_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A completion on the final watchdog cycle still counts as success.
        if (mul_done) begin
          rsp_product_d = mul_product;
          rsp_err_d     = 1'b0;
          rsp_valid_d   = to_onehot(owner_q);
          state_d       = RESP;
        end else if (timer_q == TMR_LAST) begin
          rsp_product_d = '0;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = to_onehot(owner_q);
          state_d       = RESP;
        end
      end
      RESP: begin
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      ptr_q         <= PTR_RST;
      owner_q       <= '0;
      timer_q       <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_m_q       <= '0;
      mul_q_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      timer_q       <= timer_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      mul_start_q   <= mul_start_d;
      mul_m_q       <= mul_m_d;
      mul_q_q       <= mul_q_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign mul_start   = mul_start_q;
  assign mul_m       = mul_m_q;
  assign mul_q       = mul_q_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural multiplier of programmable latency.
module tb_booth_mul_arbiter;

  localparam int N       = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req;
  logic [N*WIDTH-1:0]   req_m, req_q;
  logic [N-1:0]         gnt, rsp_valid;
  logic [2*WIDTH-1:0]   rsp_product;
  logic                 rsp_err, busy, mul_start;
  logic [WIDTH-1:0]     mul_m, mul_q;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_m       (req_m),
    .req_q       (req_q),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .mul_start   (mul_start),
    .mul_m       (mul_m),
    .mul_q       (mul_q),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [15:0] m, input logic [15:0] q);
    req_m[i*WIDTH +: WIDTH] = m;
    req_q[i*WIDTH +: WIDTH] = q;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt), 32'h0);
    check({tag, "_rspv"}, 32'(rsp_valid), 32'h0);
    check({tag, "_prod"}, rsp_product, 32'h0);
    check({tag, "_err"},  32'(rsp_err), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_start"}, 32'(mul_start), 32'h0);
    check({tag, "_mulm"}, 32'(mul_m), 32'h0);
    check({tag, "_mulq"}, 32'(mul_q), 32'h0);
  endtask

  // Waits for the grant, then answers after lat WAIT cycles (if fire) and returns the response.
  // waits = number of cycles the arbiter spent in WAIT.
  task automatic serve(input int lat, input bit fire, input bit use_calc, input logic [31:0] prod,
                       input logic [3:0] hold,
                       output logic [3:0] g, output logic [15:0] m, output logic [15:0] q,
                       output logic [3:0] v, output logic [31:0] p, output logic e,
                       output int waits);
    int n;
    int starts;
    bit seen;
    logic signed [31:0] pc;
    g = '0; m = '0; q = '0; v = '0; p = '0; e = 1'b0; waits = 0;
    n = 0;
    while (mul_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (mul_start !== 1'b1) begin
      check("start_seen", 32'h0, 32'h1);
      return;
    end
    g = gnt; m = mul_m; q = mul_q;
    req = req & (~gnt | hold);
    starts = 0;
    seen = 1'b0;
    for (int c = 1; c <= TIMEOUT + 10; c++) begin
      @(negedge clk);
      if (mul_start) starts++;
      if (rsp_valid != '0) begin
        v = rsp_valid; p = rsp_product; e = rsp_err; waits = c - 1;
        seen = 1'b1;
        mul_done = 1'b0;
        mul_product = '0;
        break;
      end
      pc = $signed(mul_m) * $signed(mul_q);
      mul_done    = fire && (c == lat);
      mul_product = (fire && c == lat) ? (use_calc ? pc : prod) : 32'h0;
    end
    check("rsp_seen", 32'(seen), 32'h1);
    check("single_start", 32'(starts), 32'h0);
  endtask

  logic [3:0]  g, v;
  logic [15:0] m, q;
  logic [31:0] p;
  logic        e;
  int          w;
  int          n, cnt;
  logic [3:0]  exp_g [6];
  logic [31:0] exp_p [6];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; req = '0; req_m = '0; req_q = '0; mul_done = 1'b0; mul_product = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: single request, -13 * 10
    set_ops(0, 16'hFFF3, 16'h000A);
    req = 4'b0001;
    serve(34, 1'b1, 1'b1, 32'h0, 4'b0000, g, m, q, v, p, e, w);
    check("t1_gnt", 32'(g), 32'h1);
    check("t1_mulm", 32'(m), 32'h0000FFF3);
    check("t1_mulq", 32'(q), 32'h0000000A);
    check("t1_rspv", 32'(v), 32'h1);
    check("t1_prod", p, 32'hFFFFFF7E);
    check("t1_err", 32'(e), 32'h0);
    check("t1_wait", 32'(w), 32'd34);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'h0);
    check("t1_hold_prod", rsp_product, 32'hFFFFFF7E);

    // 2: three simultaneous requests after reset
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) set_ops(i, 16'(i + 1), 16'(i + 2));
    exp_p[0] = 32'd2; exp_p[1] = 32'd6; exp_p[2] = 32'd12;
    req = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      serve(5, 1'b1, 1'b1, 32'h0, 4'b0000, g, m, q, v, p, e, w);
      check($sformatf("t2_gnt%0d", i), 32'(g), 32'(4'b0001 << i));
      check($sformatf("t2_rspv%0d", i), 32'(v), 32'(4'b0001 << i));
      check($sformatf("t2_prod%0d", i), p, exp_p[i]);
      check($sformatf("t2_busy_resp%0d", i), 32'(busy), 32'h1);
      @(negedge clk);
      check($sformatf("t2_busy_gap%0d", i), 32'(busy), 32'h0);
    end
    @(negedge clk);
    check("t2_idle_stay", 32'(busy), 32'h0);

    // 3: fairness between requesters 0 and 3 held high
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    set_ops(0, 16'd7, 16'hFFFE);
    set_ops(3, 16'hFED4, 16'hFF9C);
    for (int i = 0; i < 6; i++) begin
      exp_g[i] = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      exp_p[i] = (i % 2 == 0) ? 32'hFFFFFFF2 : 32'h00007530;
    end
    req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      serve(3, 1'b1, 1'b1, 32'h0, 4'b1001, g, m, q, v, p, e, w);
      if (i == 5) req = '0;
      check($sformatf("t3_gnt%0d", i), 32'(g), 32'(exp_g[i]));
      check($sformatf("t3_rspv%0d", i), 32'(v), 32'(exp_g[i]));
      check($sformatf("t3_prod%0d", i), p, exp_p[i]);
    end
    @(negedge clk);

    // 4: watchdog abort, then a normal operation
    set_ops(2, 16'd9, 16'd9);
    req = 4'b0100;
    serve(0, 1'b0, 1'b1, 32'h0, 4'b0000, g, m, q, v, p, e, w);
    check("t4_gnt", 32'(g), 32'h4);
    check("t4_rspv", 32'(v), 32'h4);
    check("t4_err", 32'(e), 32'h1);
    check("t4_prod", p, 32'h0);
    check("t4_wait", 32'(w), 32'(TIMEOUT));
    @(negedge clk);
    check("t4_idle_busy", 32'(busy), 32'h0);
    set_ops(1, 16'hFFFF, 16'hFFFF);
    req = 4'b0010;
    serve(4, 1'b1, 1'b1, 32'h0, 4'b0000, g, m, q, v, p, e, w);
    check("t4b_gnt", 32'(g), 32'h2);
    check("t4b_prod", p, 32'h1);
    check("t4b_err", 32'(e), 32'h0);
    @(negedge clk);

    // 5: reset 10 cycles into WAIT, stray mul_done while idle, then fresh arbitration
    set_ops(0, 16'd5, 16'd6);
    req = 4'b0001;
    n = 0;
    while (mul_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_start_seen", 32'(mul_start), 32'h1);
    req = '0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("t5_rst");
    rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      mul_done = (c < 5);
      @(negedge clk);
      if (rsp_valid != '0) cnt++;
    end
    mul_done = 1'b0;
    check("t5_no_rsp", 32'(cnt), 32'h0);
    set_ops(0, 16'd100, 16'd200);
    set_ops(3, 16'hFFF9, 16'd3);
    req = 4'b1001;
    serve(6, 1'b1, 1'b1, 32'h0, 4'b0000, g, m, q, v, p, e, w);
    check("t5_gnt0", 32'(g), 32'h1);
    check("t5_prod0", p, 32'h00004E20);
    serve(6, 1'b1, 1'b1, 32'h0, 4'b0000, g, m, q, v, p, e, w);
    check("t5_gnt1", 32'(g), 32'h8);
    check("t5_prod1", p, 32'hFFFFFFEB);
    @(negedge clk);

    // 6: mul_done on the final watchdog cycle
    set_ops(1, 16'd8, 16'd10);
    req = 4'b0010;
    serve(TIMEOUT, 1'b1, 1'b0, 32'h0000_0050, 4'b0000, g, m, q, v, p, e, w);
    check("t6_gnt", 32'(g), 32'h2);
    check("t6_err", 32'(e), 32'h0);
    check("t6_prod", p, 32'h0000_0050);
    check("t6_wait", 32'(w), 32'(TIMEOUT));
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
